// File: rtl/window_former.sv
// Forms 3x3 x CH-channel windows from a stream of 3-row column beats, with
// row/column position tracking and row/frame-end pulses. One-cycle latency.
module window_former #(
   parameter int DW   = 16,
   parameter int CH   = 4,
   parameter int ROWW = 8
) (
   input  logic                 CLK,
   input  logic                 RSTB,
   input  logic                 CLR,
   input  logic                 COL_VALID,
   input  logic [CH*3*DW-1:0]   COL_IN,
   input  logic [4:0]           DEPTH,
   input  logic [ROWW-1:0]      HEIGHT,
   output logic [CH*9*DW-1:0]   WIN,
   output logic                 WIN_VALID,
   output logic                 ROW_DONE,
   output logic                 FRAME_DONE
);

   localparam int CW = CH*3*DW;
   localparam int WW = CH*9*DW;

   // Handshake: a beat is taken on every CLK edge with COL_VALID=1 and CLR=0;
   // there is no ready, and the consumer must take every WIN_VALID cycle.
   logic [CW-1:0]   h0;
   logic [CW-1:0]   h1;
   logic [4:0]      col_cnt;
   logic [ROWW-1:0] row_cnt;
   logic [WW-1:0]   win_next;
   logic            col_last;
   logic            row_last;
   logic            win_ok;

   assign col_last = (col_cnt == DEPTH);
   assign row_last = (row_cnt == HEIGHT);
   assign win_ok   = (col_cnt >= 5'd2) && (row_cnt >= ROWW'(2));

   // The oldest column (k-2) is only ever needed inside the window itself, so
   // the window is assembled from h1 (k-2), h0 (k-1) and the incoming beat (k).
   for (genvar c = 0; c < CH; c++) begin : g_ch
      for (genvar j = 0; j < 3; j++) begin : g_row
         assign win_next[c*9*DW + (j*3+0)*DW +: DW] = h1[c*3*DW + j*DW +: DW];
         assign win_next[c*9*DW + (j*3+1)*DW +: DW] = h0[c*3*DW + j*DW +: DW];
         assign win_next[c*9*DW + (j*3+2)*DW +: DW] = COL_IN[c*3*DW + j*DW +: DW];
      end
   end

   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         h0         <= '0;
         h1         <= '0;
         col_cnt    <= '0;
         row_cnt    <= '0;
         WIN        <= '0;
         WIN_VALID  <= 1'b0;
         ROW_DONE   <= 1'b0;
         FRAME_DONE <= 1'b0;
      end else if (CLR) begin
         h0         <= '0;
         h1         <= '0;
         col_cnt    <= '0;
         row_cnt    <= '0;
         WIN        <= '0;
         WIN_VALID  <= 1'b0;
         ROW_DONE   <= 1'b0;
         FRAME_DONE <= 1'b0;
      end else begin
         WIN_VALID  <= 1'b0;
         ROW_DONE   <= 1'b0;
         FRAME_DONE <= 1'b0;
         if (COL_VALID) begin
            h1 <= h0;
            h0 <= COL_IN;
            if (col_last) begin
               col_cnt <= '0;
               row_cnt <= row_last ? '0 : row_cnt + ROWW'(1);
            end else begin
               col_cnt <= col_cnt + 5'd1;
            end
            // History is never cleared at a row wrap; col_cnt>=2 keeps
            // windows from straddling two rows.
            WIN_VALID  <= win_ok;
            if (win_ok) WIN <= win_next;
            ROW_DONE   <= col_last;
            FRAME_DONE <= col_last && row_last;
         end
      end
   end

endmodule
